// File: rtl/div_seq.sv
// div_seq: multi-cycle restoring radix-2 divider for DIV/DIVU, returns {remainder, quotient}.
// Define DIV_ANNUL_EN to let annul_i abort an in-flight division; otherwise annul_i is ignored.

module div_seq #(
  parameter int unsigned DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic                  signed_i,
  input  logic [DATA_W-1:0]     opdata1_i,
  input  logic [DATA_W-1:0]     opdata2_i,
  input  logic                  annul_i,
  output logic [2*DATA_W-1:0]   result_o,
  output logic                  ready_o,
  output logic                  stall_req_o
);

  localparam int unsigned     CntW    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(DATA_W - 1);

  typedef enum logic [1:0] {StIdle, StByZero, StOn, StDone} state_e;

  state_e              state_q;
  logic [CntW-1:0]     cnt_q;
  logic [DATA_W-1:0]   dividend_q;  // dividend magnitude, shifts into the quotient
  logic [DATA_W-1:0]   divisor_q;
  logic [DATA_W-1:0]   rem_q;
  logic                signed_q;
  logic                sign1_q;
  logic                sign2_q;
  logic [2*DATA_W-1:0] result_q;
  logic                ready_q;

  logic annul;
`ifdef DIV_ANNUL_EN
  assign annul = annul_i;
`else
  logic unused_annul;
  assign unused_annul = annul_i;
  assign annul        = 1'b0;
`endif

  // Operand magnitudes; the most negative value stays as its unsigned pattern.
  logic [DATA_W-1:0] op1_mag, op2_mag;
  always_comb begin
    op1_mag = (signed_i && opdata1_i[DATA_W-1]) ? ('0 - opdata1_i) : opdata1_i;
    op2_mag = (signed_i && opdata2_i[DATA_W-1]) ? ('0 - opdata2_i) : opdata2_i;
  end

  // One restoring step: shift {rem, quo} left and trial-subtract the divisor.
  logic [DATA_W:0]   shifted, diff;
  logic              ge;
  logic [DATA_W-1:0] rem_d, quo_d;
  always_comb begin
    shifted = {rem_q, dividend_q[DATA_W-1]};
    diff    = shifted - {1'b0, divisor_q};
    ge      = ~diff[DATA_W];
    rem_d   = ge ? diff[DATA_W-1:0] : shifted[DATA_W-1:0];
    quo_d   = {dividend_q[DATA_W-2:0], ge};
  end

  logic              neg_quo, neg_rem;
  logic [DATA_W-1:0] quo_fin, rem_fin;
  always_comb begin
    neg_quo = signed_q & (sign1_q ^ sign2_q);
    neg_rem = signed_q & sign1_q;
    quo_fin = neg_quo ? ('0 - dividend_q) : dividend_q;
    rem_fin = neg_rem ? ('0 - rem_q) : rem_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      dividend_q <= '0;
      divisor_q  <= '0;
      rem_q      <= '0;
      signed_q   <= 1'b0;
      sign1_q    <= 1'b0;
      sign2_q    <= 1'b0;
      result_q   <= '0;
      ready_q    <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start_i && !annul) begin
            signed_q   <= signed_i;
            sign1_q    <= opdata1_i[DATA_W-1];
            sign2_q    <= opdata2_i[DATA_W-1];
            dividend_q <= op1_mag;
            divisor_q  <= op2_mag;
            rem_q      <= '0;
            cnt_q      <= '0;
            state_q    <= (opdata2_i == '0) ? StByZero : StOn;
          end
        end
        StByZero: begin
          if (annul) begin
            state_q <= StIdle;
          end else begin
            // Clear the work registers so the DONE fix-up also yields zero.
            result_q   <= '0;
            dividend_q <= '0;
            rem_q      <= '0;
            state_q    <= StDone;
          end
        end
        StOn: begin
          if (annul) begin
            state_q <= StIdle;
          end else begin
            rem_q      <= rem_d;
            dividend_q <= quo_d;
            cnt_q      <= cnt_q + 1'b1;
            if (cnt_q == LastCnt) begin
              state_q <= StDone;
            end
          end
        end
        StDone: begin
          if (!start_i) begin
            ready_q <= 1'b0;
            state_q <= StIdle;
          end else if (!ready_q) begin
            result_q <= {rem_fin, quo_fin};
            ready_q  <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign result_o    = result_q;
  assign ready_o     = ready_q;
  assign stall_req_o = !rst && ((state_q == StIdle && start_i) || state_q == StByZero ||
                                state_q == StOn);

endmodule

// File: tb/tb_div_seq.sv
// tb_div_seq: scenario-driven bench for div_seq with a result scoreboard queue.
// Build with +define+DIV_ANNUL_EN to exercise the abort path.

module tb_div_seq;

  localparam int unsigned W = 32;

  logic           clk = 1'b0;
  logic           rst;
  logic           start_i;
  logic           signed_i;
  logic [W-1:0]   opdata1_i;
  logic [W-1:0]   opdata2_i;
  logic           annul_i;
  logic [2*W-1:0] result_o;
  logic           ready_o;
  logic           stall_req_o;

  int vectors     = 0;
  int miscompares = 0;
  logic [2*W-1:0] exp_q[$];

  always #5 clk = ~clk;

  div_seq #(.DATA_W(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start_i),
    .signed_i   (signed_i),
    .opdata1_i  (opdata1_i),
    .opdata2_i  (opdata2_i),
    .annul_i    (annul_i),
    .result_o   (result_o),
    .ready_o    (ready_o),
    .stall_req_o(stall_req_o)
  );

  // Reference model built on the simulator's 64-bit truncating division.
  function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b,
                                          input bit s);
    longint sa, sb, q, r;
    if (b == 32'd0) return 64'd0;
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  // Called at a negedge in IDLE; returns posedges until ready (bounded) and stall cycles seen.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input bit s,
                       input logic [63:0] exp, output int lat, output int stalls);
    exp_q.push_back(exp);
    opdata1_i = a;
    opdata2_i = b;
    signed_i  = s;
    start_i   = 1'b1;
    #1;
    stalls = (stall_req_o === 1'b1) ? 1 : 0;
    lat    = 0;
    while (lat < 80) begin
      @(negedge clk);
      lat++;
      // Operands must be ignored once accepted.
      opdata1_i = $urandom;
      opdata2_i = $urandom;
      signed_i  = 1'($urandom_range(0, 1));
      if (stall_req_o === 1'b1) stalls++;
      if (ready_o === 1'b1) break;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; start_i = 1'b1; signed_i = 1'b0; annul_i = 1'b0;
    opdata1_i = '0; opdata2_i = '0;
    #2;
    vectors++;
    if (result_o !== 64'd0 || ready_o !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_outputs: got result=%h ready=%b expected 0/0", result_o, ready_o);
    end
    vectors++;
    if (stall_req_o !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_stall: got %b expected 0", stall_req_o);
    end
    start_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    vectors++;
    if (ready_o !== 1'b0 || stall_req_o !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_after_reset: got ready=%b stall=%b expected 0/0", ready_o, stall_req_o);
    end
  endtask

  task automatic test_unsigned;
    int lat, st;
    logic [63:0] exp;
    issue(32'd100, 32'd7, 1'b0, 64'h00000002_0000000E, lat, st);
    exp = exp_q.pop_front();
    vectors++;
    if (lat !== 34) begin
      miscompares++; $display("FAIL udiv_latency: got %0d expected 34", lat);
    end
    vectors++;
    if (st !== 33) begin
      miscompares++; $display("FAIL udiv_stall_cycles: got %0d expected 33", st);
    end
    vectors++;
    if (result_o !== exp) begin
      miscompares++; $display("FAIL udiv_result: got %h expected %h", result_o, exp);
    end
    start_i = 1'b0;
    @(negedge clk);
    vectors++;
    if (ready_o !== 1'b0 || result_o !== exp) begin
      miscompares++;
      $display("FAIL udiv_release: got ready=%b result=%h expected 0/%h", ready_o, result_o, exp);
    end
  endtask

  task automatic test_signed;
    logic [31:0] a_tab [2] = '{32'hFFFFFFF9, 32'h00000007};
    logic [31:0] b_tab [2] = '{32'h00000002, 32'hFFFFFFFE};
    logic [63:0] e_tab [2] = '{64'hFFFFFFFF_FFFFFFFD, 64'h00000001_FFFFFFFD};
    for (int i = 0; i < 2; i++) begin
      int lat, st;
      logic [63:0] exp;
      issue(a_tab[i], b_tab[i], 1'b1, e_tab[i], lat, st);
      exp = exp_q.pop_front();
      vectors++;
      if (lat !== 34 || result_o !== exp) begin
        miscompares++;
        $display("FAIL signed_div[%0d]: got lat=%0d result=%h expected 34/%h",
                 i, lat, result_o, exp);
      end
      start_i = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic test_byzero;
    int lat, st;
    logic [63:0] exp;
    issue(32'h12345678, 32'd0, 1'b0, 64'd0, lat, st);
    exp = exp_q.pop_front();
    vectors++;
    if (lat !== 3) begin
      miscompares++; $display("FAIL byzero_latency: got %0d expected 3", lat);
    end
    vectors++;
    if (st !== 2) begin
      miscompares++; $display("FAIL byzero_stall_cycles: got %0d expected 2", st);
    end
    vectors++;
    if (result_o !== exp) begin
      miscompares++; $display("FAIL byzero_result: got %h expected %h", result_o, exp);
    end
    start_i = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_overflow;
    bit          s_tab [2] = '{1'b1, 1'b0};
    logic [63:0] e_tab [2] = '{64'h00000000_80000000, 64'h80000000_00000000};
    for (int i = 0; i < 2; i++) begin
      int lat, st;
      logic [63:0] exp;
      issue(32'h80000000, 32'hFFFFFFFF, s_tab[i], e_tab[i], lat, st);
      exp = exp_q.pop_front();
      vectors++;
      if (lat !== 34 || result_o !== exp) begin
        miscompares++;
        $display("FAIL overflow[%0d]: got lat=%0d result=%h expected 34/%h",
                 i, lat, result_o, exp);
      end
      start_i = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back;
    int lat, st, drops;
    logic [63:0] exp;
    issue(32'd1000, 32'd10, 1'b0, 64'h00000000_00000064, lat, st);
    exp = exp_q.pop_front();
    drops = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (ready_o !== 1'b1 || result_o !== exp) drops++;
    end
    vectors++;
    if (drops !== 0) begin
      miscompares++; $display("FAIL done_hold: got %0d bad cycles expected 0", drops);
    end
    start_i = 1'b0;
    @(negedge clk);
    vectors++;
    if (ready_o !== 1'b0 || result_o !== exp) begin
      miscompares++;
      $display("FAIL b2b_release: got ready=%b result=%h expected 0/%h", ready_o, result_o, exp);
    end
    issue(32'hFFFFFF9C, 32'd7, 1'b1, 64'hFFFFFFFE_FFFFFFF2, lat, st);
    exp = exp_q.pop_front();
    vectors++;
    if (lat !== 34 || result_o !== exp) begin
      miscompares++;
      $display("FAIL b2b_second: got lat=%0d result=%h expected 34/%h", lat, result_o, exp);
    end
    start_i = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_annul;
    logic [63:0] held;
    int k;
    held      = result_o;
    opdata1_i = 32'd1000;
    opdata2_i = 32'd3;
    signed_i  = 1'b0;
    start_i   = 1'b1;
    for (k = 0; k < 11; k++) @(negedge clk);
    // Counter now holds 10.
    annul_i = 1'b1;
`ifdef DIV_ANNUL_EN
    start_i = 1'b0;
    @(negedge clk);
    annul_i = 1'b0;
    vectors++;
    if (stall_req_o !== 1'b0 || ready_o !== 1'b0 || result_o !== held) begin
      miscompares++;
      $display("FAIL annul_abort: got stall=%b ready=%b result=%h expected 0/0/%h",
               stall_req_o, ready_o, result_o, held);
    end
    k = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ready_o === 1'b1 || stall_req_o === 1'b1) k++;
    end
    vectors++;
    if (k !== 0) begin
      miscompares++; $display("FAIL annul_quiet: got %0d active cycles expected 0", k);
    end
`else
    begin
      logic [63:0] exp;
      exp_q.push_back(64'h00000001_0000014D);
      @(negedge clk);
      annul_i = 1'b0;
      k = 12;
      while (k < 80 && ready_o !== 1'b1) begin
        @(negedge clk);
        k++;
      end
      exp = exp_q.pop_front();
      vectors++;
      if (k !== 34 || result_o !== exp) begin
        miscompares++;
        $display("FAIL annul_ignored: got lat=%0d result=%h expected 34/%h", k, result_o, exp);
      end
      start_i = 1'b0;
      @(negedge clk);
    end
`endif
  endtask

  task automatic test_async_reset;
    int lat, st;
    logic [63:0] exp;
    opdata1_i = 32'h12345678;
    opdata2_i = 32'h00000011;
    signed_i  = 1'b0;
    start_i   = 1'b1;
    for (int i = 0; i < 21; i++) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    vectors++;
    if (ready_o !== 1'b0 || result_o !== 64'd0 || stall_req_o !== 1'b0) begin
      miscompares++;
      $display("FAIL async_reset: got ready=%b result=%h stall=%b expected 0/0/0",
               ready_o, result_o, stall_req_o);
    end
    start_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    issue(32'd9, 32'd3, 1'b0, 64'h00000000_00000003, lat, st);
    exp = exp_q.pop_front();
    vectors++;
    if (lat !== 34 || result_o !== exp) begin
      miscompares++;
      $display("FAIL post_reset_div: got lat=%0d result=%h expected 34/%h", lat, result_o, exp);
    end
    start_i = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_random;
    for (int i = 0; i < 8; i++) begin
      int lat, st;
      logic [31:0] a, b;
      bit s;
      logic [63:0] exp;
      a = $urandom;
      b = (i % 3 == 0) ? 32'($urandom_range(1, 255)) : $urandom;
      if (i == 5) b = 32'd0;
      s = 1'($urandom_range(0, 1));
      issue(a, b, s, ref_div(a, b, s), lat, st);
      exp = exp_q.pop_front();
      vectors++;
      if (lat !== ((b == 32'd0) ? 3 : 34) || result_o !== exp) begin
        miscompares++;
        $display("FAIL random[%0d] %h/%h s=%0d: got lat=%0d result=%h expected %h",
                 i, a, b, s, lat, result_o, exp);
      end
      start_i = 1'b0;
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset;
    test_unsigned;
    test_signed;
    test_byzero;
    test_overflow;
    test_back_to_back;
    test_annul;
    test_async_reset;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/div_seq.md
Name: div_seq

Overview:
- Multi-cycle signed/unsigned integer divider sequencer for DIV/DIVU.
- Sits beside the EX stage.
- Accepts operands under a start/ready handshake and asserts a stall request to the pipeline controller while busy.
- Returns {remainder, quotient}; EX forwards these as hi/lo with the HI/LO write enable toward MEM and the HI/LO register file.

Parameters:
- DATA_W, 32, operand width; counter width = clog2(DATA_W).

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- start_i  input  1  request a division; held high by EX until ready_o is seen
- signed_i  input  1  1 = DIV (two's complement), 0 = DIVU
- opdata1_i  input  DATA_W  dividend
- opdata2_i  input  DATA_W  divisor
- annul_i  input  1  abort request (flush); active only with DIV_ANNUL_EN
- result_o  output  2*DATA_W  {remainder, quotient}; upper half goes to hi, lower half to lo
- ready_o  output  1  result valid
- stall_req_o  output  1  pipeline stall request (combinational)

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous and active-high; when asserted, the block returns to IDLE immediately, including mid-operation.
- Reset values: state=IDLE, result_o=0, ready_o=0, iteration counter=0, internal dividend/divisor/partial-remainder registers=0.
- FSM states: IDLE, BYZERO, ON, DONE.
- IDLE:
  - start_i=1 at an edge latches operands, signed_i and operand signs.
  - Next state is BYZERO if opdata2_i==0, else ON with cnt=0.
  - start_i=0 stays in IDLE.
- BYZERO: one cycle; result register := 0; next state DONE.
- ON:
  - One restoring radix-2 iteration per cycle on magnitudes.
  - Shift {rem, quo} left by 1, trial-subtract the divisor from the upper DATA_W+1 bits, set the quotient LSB if non-negative.
  - cnt increments each cycle. The iteration with cnt==DATA_W-1 is the last; next state is DONE.
- Signed rules (signed_i=1):
  - Operate on absolute values.
  - Quotient is negated iff dividend and divisor signs differ.
  - Remainder takes the dividend's sign.
  - abs(0x80000000) is treated as unsigned 0x80000000, so 0x80000000 / -1 gives quotient 0x80000000 and remainder 0 (no trap).
- DONE:
  - ready_o=1 and result_o holds the final value.
  - Stays in DONE while start_i=1. When start_i=0 at an edge: next state IDLE, ready_o→0, result_o is held (not cleared).
- Latency for DATA_W=32, counting from the edge that samples start_i (E0):
  - Normal: ready_o=1 in the cycle after edge E0+33.
  - Divide by zero: ready_o=1 after edge E0+2.
- stall_req_o = (state==IDLE && start_i) || state==BYZERO || state==ON. It is 0 in DONE and under reset.
- ready_o and result_o are registered. stall_req_o is the only combinational output.
- start_i toggling or operand changes after acceptance are ignored until DONE/IDLE. Operands are sampled only at acceptance.
- Back-to-back operation: a new start_i is accepted only from IDLE, so at least one IDLE cycle separates results.

Optional Feature:
- Macro: DIV_ANNUL_EN.
- Defined: annul_i=1 at an edge in BYZERO or ON forces the next state to IDLE. No DONE, ready_o stays 0, result_o is unchanged, and stall_req_o drops in the following cycle. annul_i in IDLE blocks acceptance of start_i that cycle. annul_i in DONE has no effect.
- Undefined: annul_i is ignored, the port remains, and a started division always runs to DONE.

Test Plan:
- Unsigned 100/7 (signed_i=0): start at E0 → stall_req_o high for 33 cycles, ready_o after E0+33, result_o=0x00000002_0000000E; drop start_i → IDLE, ready_o=0 next cycle.
- Signed -7/2 (0xFFFFFFF9 / 0x00000002): result_o=0xFFFFFFFF_FFFFFFFD. Signed 7/-2: result_o=0x00000001_FFFFFFFD.
- Divide by zero (0x12345678 / 0): ready_o after E0+2, result_o=0, stall_req_o high for exactly the IDLE-accept and BYZERO cycles.
- Signed overflow 0x80000000 / 0xFFFFFFFF: result_o=0x00000000_80000000. Same operands unsigned: result_o=0x80000000_00000000.
- With DIV_ANNUL_EN: pulse annul_i when cnt==10 → IDLE next cycle, ready_o never asserts, stall_req_o=0. Without the macro, the same stimulus completes normally with the correct result.
- Assert rst asynchronously mid-ON (cnt==20) → state IDLE, ready_o=0, result_o=0, stall_req_o=0 immediately. A fresh 9/3 after release gives 0x00000000_00000003.
